// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out bus between a word source and piso_serializer.
// The slave side is the serializer itself; the master side is the word source.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] pdin;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_end;
  logic             busy;

  modport master (
    output pdin, load_valid,
    input  load_ready, dout, dout_valid, frame_end, busy
  );

  modport slave (
    input  pdin, load_valid,
    output load_ready, dout, dout_valid, frame_end, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter feeding the downstream SIPO, LSB first,
// with an optional idle gap after every frame.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic              clk,
  input logic              reset,
  piso_serializer_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_gapCount;
  logic [WIDTH-1:0] r_shift;
  logic             r_dout;
  logic             r_doutValid;
  logic             r_frameEnd;

  state_t           w_stateNext;
  logic [CW-1:0]    w_countNext;
  logic [3:0]       w_gapNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_doutNext;
  logic             w_validNext;
  logic             w_frameEndNext;
  logic             w_loadReady;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_gapCount  <= '0;
      r_shift     <= '0;
      r_dout      <= IDLE_LEVEL;
      r_doutValid <= 1'b0;
      r_frameEnd  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_count     <= w_countNext;
      r_gapCount  <= w_gapNext;
      r_shift     <= w_shiftNext;
      r_dout      <= w_doutNext;
      r_doutValid <= w_validNext;
      r_frameEnd  <= w_frameEndNext;
    end
  end

  // With no gap, the last-bit cycle also accepts the next word so frames chain without a bubble.
  always_comb begin
    w_loadReady = 1'b0;
    case (r_state)
      S_IDLE:  w_loadReady = 1'b1;
      S_SHIFT: w_loadReady = (GAP == 0) && (r_count == LAST);
      default: w_loadReady = 1'b0;
    endcase
    w_accept = bus.load_valid && w_loadReady;

    w_stateNext    = r_state;
    w_countNext    = r_count;
    w_gapNext      = r_gapCount;
    w_shiftNext    = r_shift;
    w_doutNext     = IDLE_LEVEL;
    w_validNext    = 1'b0;
    w_frameEndNext = 1'b0;

    if (w_accept) begin
      w_stateNext = S_SHIFT;
      w_countNext = '0;
      w_shiftNext = bus.pdin;
      w_doutNext  = bus.pdin[0];
      w_validNext = 1'b1;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (r_count == LAST) begin
            if (GAP == 0) begin
              w_stateNext = S_IDLE;
            end else begin
              w_stateNext = S_GAP;
              w_gapNext   = '0;
            end
          end else begin
            w_countNext    = CW'(r_count + 1'b1);
            w_shiftNext    = r_shift >> 1;
            w_doutNext     = r_shift[1];
            w_validNext    = 1'b1;
            w_frameEndNext = (CW'(r_count + 1'b1) == LAST);
          end
        end
        S_GAP: begin
          if (r_gapCount == GAP_LAST) begin
            w_stateNext = S_IDLE;
          end else begin
            w_gapNext = r_gapCount + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.load_ready = w_loadReady;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_doutValid;
  assign bus.frame_end  = r_frameEnd;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a no-gap and a two-cycle-gap instance share one
// stimulus stream and are each compared every cycle against a frame-position model.
module tb_piso_serializer;

  localparam int WIDTH = 4;
  localparam int GAP_A = 0;
  localparam int GAP_B = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             loadValid = 1'b0;
  logic [WIDTH-1:0] pdin = '0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(WIDTH)) busA ();
  piso_serializer_if #(.WIDTH(WIDTH)) busB ();

  assign busA.pdin       = pdin;
  assign busA.load_valid = loadValid;
  assign busB.pdin       = pdin;
  assign busB.load_valid = loadValid;

  piso_serializer #(.WIDTH(WIDTH), .GAP(GAP_A), .IDLE_LEVEL(1'b0)) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );
  piso_serializer #(.WIDTH(WIDTH), .GAP(GAP_B), .IDLE_LEVEL(1'b0)) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  logic outDout[2], outValid[2], outFe[2], outReady[2], outBusy[2];
  assign outDout[0]  = busA.dout;
  assign outValid[0] = busA.dout_valid;
  assign outFe[0]    = busA.frame_end;
  assign outReady[0] = busA.load_ready;
  assign outBusy[0]  = busA.busy;
  assign outDout[1]  = busB.dout;
  assign outValid[1] = busB.dout_valid;
  assign outFe[1]    = busB.frame_end;
  assign outReady[1] = busB.load_ready;
  assign outBusy[1]  = busB.busy;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] w);
    @(negedge clk);
    reset     = r;
    loadValid = v;
    pdin      = w;
  endtask

  // Model: a frame occupies WIDTH data slots then GAP idle slots; remain counts slots left.
  int               remain[2];
  logic [WIDTH-1:0] word[2];
  logic [WIDTH-1:0] sipo[2];
  int               gapOf[2];
  bit               modelOn = 1'b0;

  initial begin
    gapOf[0] = GAP_A;
    gapOf[1] = GAP_B;
    remain[0] = 0;
    remain[1] = 0;
  end

  function automatic bit modelReady(input int d);
    return (remain[d] == 0) || (gapOf[d] == 0 && remain[d] == 1);
  endfunction

  initial begin
    logic sDout[2], sValid[2], sFe[2];
    int   idx;
    logic expDout, expValid, expFe;
    bit   acc;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        sDout[d]  = outDout[d];
        sValid[d] = outValid[d];
        sFe[d]    = outFe[d];
      end
      if (modelOn) begin
        for (int d = 0; d < 2; d++) begin
          idx      = WIDTH + gapOf[d] - remain[d];
          expDout  = 1'b0;
          expValid = 1'b0;
          expFe    = 1'b0;
          if (remain[d] > 0 && idx < WIDTH) begin
            expDout  = word[d][idx];
            expValid = 1'b1;
            expFe    = (idx == WIDTH - 1);
          end
          checkOutput($sformatf("gap%0d dout", gapOf[d]), sDout[d], expDout);
          checkOutput($sformatf("gap%0d dout_valid", gapOf[d]), sValid[d], expValid);
          checkOutput($sformatf("gap%0d frame_end", gapOf[d]), sFe[d], expFe);
          checkOutput($sformatf("gap%0d load_ready", gapOf[d]), outReady[d], modelReady(d));
          checkOutput($sformatf("gap%0d busy", gapOf[d]), outBusy[d], remain[d] > 0);
        end
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          remain[d] = 0;
        end else if (modelOn) begin
          acc = loadValid && modelReady(d);
          if (sValid[d]) begin
            sipo[d] = {sDout[d], sipo[d][WIDTH-1:1]};
            if (sFe[d]) checkOutput($sformatf("gap%0d sipo word", gapOf[d]), sipo[d], word[d]);
          end
          if (remain[d] > 0) remain[d]--;
          if (acc) begin
            remain[d] = WIDTH + gapOf[d];
            word[d]   = pdin;
          end
        end
      end
      if (reset) modelOn = 1'b1;
    end
  end

  initial begin
    logic [7:0]  vD, vV, vF, vR;
    logic [10:0] wD, wV, wR;

    applyStimulus(1'b1, 1'b0, 4'b0000);

    // Single word, no gap: 1011 leaves as 1,1,0,1.
    applyStimulus(1'b0, 1'b1, 4'b1011);
    checkOutput("t1 ready after reset", outReady[0], 1);
    checkOutput("t1 busy after reset", outBusy[0], 0);
    checkOutput("t1 dout after reset", outDout[0], 0);
    vD = '0; vV = '0; vF = '0; vR = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0000);
      vD[i] = outDout[0];
      vV[i] = outValid[0];
      vF[i] = outFe[0];
    end
    checkOutput("t1 dout seq", vD[3:0], 4'b1011);
    checkOutput("t1 valid seq", vV[3:0], 4'b1111);
    checkOutput("t1 frame_end seq", vF[3:0], 4'b1000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("t1 idle valid", outValid[0], 0);
    checkOutput("t1 sipo", sipo[0], 4'b1011);

    // Back-to-back words without a bubble.
    applyStimulus(1'b0, 1'b1, 4'b0110);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, (i < 4), 4'b1001);
      vD[i] = outDout[0];
      vV[i] = outValid[0];
      vF[i] = outFe[0];
      vR[i] = outReady[0];
    end
    checkOutput("t2 dout seq", vD, 8'b10010110);
    checkOutput("t2 valid seq", vV, 8'b11111111);
    checkOutput("t2 frame_end seq", vF, 8'b10001000);
    checkOutput("t2 ready seq", vR[3:0], 4'b1000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("t2 idle valid", outValid[0], 0);

    // Two-cycle gap instance.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, (i < 7), 4'b0001);
      wD[i] = outDout[1];
      wV[i] = outValid[1];
      wR[i] = outReady[1];
    end
    checkOutput("t3 dout seq", wD, 11'b00010001111);
    checkOutput("t3 valid seq", wV, 11'b11110001111);
    checkOutput("t3 ready seq", wR, 11'b00001000000);

    // Reset in the middle of a frame.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b1010);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("t4 bit0", outDout[0], 0);
    checkOutput("t4 bit0 valid", outValid[0], 1);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("t4 bit1", outDout[0], 1);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("t4 dout after reset", outDout[0], 0);
    checkOutput("t4 valid after reset", outValid[0], 0);
    checkOutput("t4 busy after reset", outBusy[0], 0);
    checkOutput("t4 ready after reset", outReady[0], 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0000);
      vV[i] = outValid[0];
    end
    checkOutput("t4 no leftover bits", vV[2:0], 3'b000);

    // Reset wins over a simultaneous load.
    applyStimulus(1'b1, 1'b1, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("t5 ready gap%0d", gapOf[d]), outReady[d], 1);
      checkOutput($sformatf("t5 busy gap%0d", gapOf[d]), outBusy[d], 0);
      checkOutput($sformatf("t5 valid gap%0d", gapOf[d]), outValid[d], 0);
    end
    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("t5 still idle", outValid[0], 0);

    // pdin changes and a mid-frame load pulse must not disturb the word in flight.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b1101);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, (i == 1), 4'b0000);
      vD[i] = outDout[0];
      vV[i] = outValid[0];
      vR[i] = outReady[0];
    end
    checkOutput("t6 dout seq", vD[3:0], 4'b1101);
    checkOutput("t6 ready mid-frame", vR[1], 0);
    checkOutput("t6 pulse ignored", vV[5:4], 2'b00);

    // Randomized traffic with occasional resets.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0), 4'($urandom));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
